reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised multi-port register file with a per-register scoreboard. Next generation of the 8x16 two-read, one-write register file.
- Adds a configurable read-port count and two write ports: port A for the ALU, port B for memory/long-latency results.
- Adds busy bits that track reserved pending writes, with an optional write-to-read bypass. Sits between decode (reads, reservations) and writeback.

Parameters:
- WIDTH, 16, register data width in bits.
- DEPTH, 8, number of registers. Must be a power of 2, at least 2.
- NREAD, 2, number of independent read ports.
- ZERO_R0, 0. When 1, R0 always reads 0, ignores writes, and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_sel  in  NREAD x SELW  read selects. SELW = $clog2(DEPTH).
- rd_data  out  NREAD x WIDTH  read data.
- rd_busy  out  NREAD  busy bit of each selected register.
- wa_en  in  1  port A write enable.
- wa_sel  in  SELW  port A destination.
- wa_data  in  WIDTH  port A data.
- wb_en  in  1  port B write enable. Also releases the reservation.
- wb_sel  in  SELW  port B destination.
- wb_data  in  WIDTH  port B data.
- rsv_en  in  1  reserve request.
- rsv_sel  in  SELW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle (combinational).
- busy_vec  out  DEPTH  all busy bits.
- err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, reset=1 at a rising clk edge):
  - All registers go to 0, all busy bits to 0, err to 0.
  - Reset overrides every same-cycle write and reserve.
  - Outputs after reset: rd_data=0, rd_busy=0, busy_vec=0, err=0.
  - rsv_ok follows its combinational definition.
- Reads:
  - Combinational, zero latency: rd_data[i] = R[rd_sel[i]] and rd_busy[i] = busy[rd_sel[i]].
  - Each read port is independent; any number of ports may select the same register.
- Writes (rising edge, reset=0):
  - Port A writes R[wa_sel] <= wa_data if wa_en=1 and busy[wa_sel]=0.
  - Port A write to a busy register: the write is dropped and err is set to 1 (sticky).
  - Port B writes R[wb_sel] <= wb_data if wb_en=1, and clears busy[wb_sel].
  - Port B write to a non-busy register: the write still occurs and err is set to 1.
  - Both ports, same register: port B's data wins. Port A's write is dropped without error only when that register was busy at the edge.
  - Both ports, different registers: both writes occur.
- Reservation:
  - rsv_ok = rsv_en && (busy[rsv_sel]==0 || (wb_en && wb_sel==rsv_sel)).
  - When rsv_ok=1, busy[rsv_sel] is set at the edge. Set has priority over a same-cycle port B release of the same register, so the register stays busy.
  - rsv_en to a busy register with no same-cycle release: rsv_ok=0 and no state change. This is not an error; the requester retries.
- ZERO_R0=1:
  - rd_data is 0 for sel=0.
  - Writes to R0 are ignored without error.
  - rsv_ok=1 for sel=0 but the busy bit is never set.
  - Port B write to R0 does not set err.
- Data path: no arithmetic. Data is stored exactly as WIDTH bits. Selects are SELW bits wide, so no out-of-range index is possible.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined: a read whose rd_sel matches an effective same-cycle write returns that write data combinationally.
  - Priority: port B over port A over stored value.
  - A dropped port A write is not bypassed.
  - rd_busy also reflects the same-cycle release (0) or reserve (1), with reserve taking priority.
- Not defined: reads return the stored pre-edge value. New data is visible from the cycle after the write.

Decomposition:
- Shared package reg_file_pkg:
  - typedefs reg16_t and reg_sel_t (retained for the existing 8x16 configuration).
  - default constants RF_WIDTH=16, RF_DEPTH=8, RF_NREAD=2.
- One natural sub-module, rf_scoreboard: holds the busy bits and generates rsv_ok, the release/set logic, and the err conditions. The storage array and read muxes stay in reg_file_sb.

Test Plan:
1. Reset, then wa_en writes R3=16'h1234 → next cycle rd_sel[0]=3 gives 16'h1234 and rd_busy[0]=0. Without bypass, the same-cycle read gives 0.
2. rsv_en sel=5 → rsv_ok=1 and busy_vec=8'h20. Then wa_en sel=5 data 16'hBEEF → R5 unchanged and err=1. Then wb_en sel=5 data 16'hCAFE → R5=16'hCAFE and busy_vec=0.
3. R2 busy, and in the same cycle rsv_en sel=2 with wb_en sel=2 data 16'h0042 → rsv_ok=1, R2=16'h0042, busy[2] stays 1, err stays 0.
4. R1 not busy, wa_en and wb_en both to sel=1 with data 16'hAAAA and 16'h5555 → R1=16'h5555 and err=1 (port B write to non-busy register).
5. NREAD=4, DEPTH=16, ZERO_R0=1 → all four ports read distinct registers correctly. wa_en sel=0 data 16'hFFFF → rd_data for sel=0 stays 0 and err=0. rsv_en sel=0 → busy_vec stays 0.
6. Reset asserted in the same cycle as wa_en sel=4 and rsv_en sel=6 → R4=0, busy_vec=0, err=0. With REG_FILE_SB_BYPASS_EN, a port B write to sel=7 with data 16'h7777 reads back 16'h7777 in the same cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the scoreboarded register file family.
//   RF_WIDTH / RF_DEPTH / RF_NREAD : default geometry (8 registers x 16 bits,
//                                    two read ports).
//   reg16_t / reg_sel_t            : data and select types of that default
//                                    8x16 configuration, kept so existing users
//                                    of the two-read one-write file still build.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_NREAD = 2;
  localparam int RF_SELW  = $clog2(RF_DEPTH);

  typedef logic [RF_WIDTH-1:0] reg16_t;
  typedef logic [RF_SELW-1:0]  reg_sel_t;

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy-bit tracker for reg_file_sb. A register is reserved by decode (rsv_*)
// and released by the long-latency writeback port B. This block owns the busy
// bits and the sticky error flag, and decides which writes take effect.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   wa_en/wa_sel      port A write request (ALU)
//   wb_en/wb_sel      port B write request (memory), also releases busy
//   rsv_en/rsv_sel    reservation request
//   wa_wr, wb_wr      effective (storage-updating) writes for A and B
//   rsv_ok            reservation accepted this cycle (combinational)
//   busy_vec          registered busy bits
//   busy_view         busy bits as seen by the read ports: the registered
//                     bits, or the next-cycle bits when BYPASS is set
//   err               sticky error flag
// -----------------------------------------------------------------------------
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH   = RF_DEPTH,
  parameter int ZERO_R0 = 0,
  parameter bit BYPASS  = 1'b0,
  localparam int SELW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wa_en,
  input  logic [SELW-1:0]  wa_sel,
  input  logic             wb_en,
  input  logic [SELW-1:0]  wb_sel,
  input  logic             rsv_en,
  input  logic [SELW-1:0]  rsv_sel,
  output logic             wa_wr,
  output logic             wb_wr,
  output logic             rsv_ok,
  output logic [DEPTH-1:0] busy_vec,
  output logic [DEPTH-1:0] busy_view,
  output logic             err
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_q, err_d;

  logic wa_r0, wb_r0, rsv_r0;
  logic wa_busy, wb_busy;
  logic err_a, err_b;

  always_comb begin
    // With ZERO_R0, register 0 is a constant: never written, never busy.
    wa_r0   = (ZERO_R0 != 0) && (wa_sel == '0);
    wb_r0   = (ZERO_R0 != 0) && (wb_sel == '0);
    rsv_r0  = (ZERO_R0 != 0) && (rsv_sel == '0);

    wa_busy = busy_q[wa_sel];
    wb_busy = busy_q[wb_sel];

    // A reservation may reuse a register that port B is releasing this cycle.
    rsv_ok  = rsv_en && (!busy_q[rsv_sel] || (wb_en && (wb_sel == rsv_sel)));

    wa_wr   = wa_en && !wa_busy && !wa_r0;
    wb_wr   = wb_en && !wb_r0;

    // Port A hitting a busy register is an error, except when port B retires
    // that same register in the same cycle (B legitimately owns it).
    err_a   = wa_en && wa_busy && !(wb_en && (wb_sel == wa_sel));
    // Port B retiring something that was never reserved.
    err_b   = wb_en && !wb_busy && !wb_r0;

    busy_d = busy_q;
    if (wb_wr) begin
      busy_d[wb_sel] = 1'b0;
    end
    // Set after clear: a same-cycle re-reservation keeps the register busy.
    if (rsv_ok && !rsv_r0) begin
      busy_d[rsv_sel] = 1'b1;
    end

    err_d = err_q | err_a | err_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec  = busy_q;
  assign busy_view = BYPASS ? busy_d : busy_q;
  assign err       = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Multi-port register file with a per-register busy scoreboard. Sits between
// decode (reads, reservations) and writeback (port A = ALU, port B = memory).
//
// Ports:
//   clk, reset   clock (rising edge), synchronous active-high reset
//   rd_sel[i]    read select of port i (NREAD ports, SELW bits each)
//   rd_data[i]   read data of port i (combinational)
//   rd_busy[i]   busy bit of the register selected by port i
//   wa_*         port A write (dropped with error if target busy)
//   wb_*         port B write, releases the target's busy bit
//   rsv_*        reservation request, rsv_ok = accepted this cycle
//   busy_vec     all busy bits
//   err          sticky error flag
//
// Build option:
//   REG_FILE_SB_BYPASS_EN  when defined, reads see same-cycle effective writes
//                          (port B over port A over stored value) and rd_busy
//                          sees same-cycle release/reserve. When undefined,
//                          reads return the stored pre-edge state.
// -----------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int NREAD   = RF_NREAD,
  parameter int ZERO_R0 = 0,
  localparam int SELW   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREAD-1:0][SELW-1:0]   rd_sel,
  output logic [NREAD-1:0][WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]             rd_busy,
  input  logic                         wa_en,
  input  logic [SELW-1:0]              wa_sel,
  input  logic [WIDTH-1:0]             wa_data,
  input  logic                         wb_en,
  input  logic [SELW-1:0]              wb_sel,
  input  logic [WIDTH-1:0]             wb_data,
  input  logic                         rsv_en,
  input  logic [SELW-1:0]              rsv_sel,
  output logic                         rsv_ok,
  output logic [DEPTH-1:0]             busy_vec,
  output logic                         err
);

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic             wa_wr, wb_wr;
  logic [DEPTH-1:0] busy_view;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS_ON)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wa_en     (wa_en),
    .wa_sel    (wa_sel),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .rsv_en    (rsv_en),
    .rsv_sel   (rsv_sel),
    .wa_wr     (wa_wr),
    .wb_wr     (wb_wr),
    .rsv_ok    (rsv_ok),
    .busy_vec  (busy_vec),
    .busy_view (busy_view),
    .err       (err)
  );

  // Port B is applied last so it wins a same-register collision.
  always_comb begin
    regs_d = regs_q;
    if (wa_wr) begin
      regs_d[wa_sel] = wa_data;
    end
    if (wb_wr) begin
      regs_d[wb_sel] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_data[i] = regs_q[rd_sel[i]];
`ifdef REG_FILE_SB_BYPASS_EN
      // Only effective writes forward; a dropped port A write is invisible.
      if (wa_wr && (wa_sel == rd_sel[i])) begin
        rd_data[i] = wa_data;
      end
      if (wb_wr && (wb_sel == rd_sel[i])) begin
        rd_data[i] = wb_data;
      end
`endif
      if ((ZERO_R0 != 0) && (rd_sel[i] == '0)) begin
        rd_data[i] = '0;
      end
      rd_busy[i] = busy_view[rd_sel[i]];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: two instances, the default 8x16 / 2-read
// file and a 16-deep / 4-read file with a hardwired R0.
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_BVEC = 2;
  localparam int K_ERR  = 3;
  localparam int K_RSV  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: defaults (WIDTH 16, DEPTH 8, NREAD 2, ZERO_R0 0)
  logic [1:0][2:0]  d0_rd_sel;
  logic [1:0][15:0] d0_rd_data;
  logic [1:0]       d0_rd_busy;
  logic             d0_wa_en, d0_wb_en, d0_rsv_en, d0_rsv_ok, d0_err;
  logic [2:0]       d0_wa_sel, d0_wb_sel, d0_rsv_sel;
  logic [15:0]      d0_wa_data, d0_wb_data;
  logic [7:0]       d0_busy_vec;

  // Instance 1: DEPTH 16, NREAD 4, ZERO_R0 1
  logic [3:0][3:0]  d1_rd_sel;
  logic [3:0][15:0] d1_rd_data;
  logic [3:0]       d1_rd_busy;
  logic             d1_wa_en, d1_wb_en, d1_rsv_en, d1_rsv_ok, d1_err;
  logic [3:0]       d1_wa_sel, d1_wb_sel, d1_rsv_sel;
  logic [15:0]      d1_wa_data, d1_wb_data;
  logic [15:0]      d1_busy_vec;

  reg_file_sb dut0 (
    .clk(clk), .reset(reset),
    .rd_sel(d0_rd_sel), .rd_data(d0_rd_data), .rd_busy(d0_rd_busy),
    .wa_en(d0_wa_en), .wa_sel(d0_wa_sel), .wa_data(d0_wa_data),
    .wb_en(d0_wb_en), .wb_sel(d0_wb_sel), .wb_data(d0_wb_data),
    .rsv_en(d0_rsv_en), .rsv_sel(d0_rsv_sel), .rsv_ok(d0_rsv_ok),
    .busy_vec(d0_busy_vec), .err(d0_err)
  );

  reg_file_sb #(.WIDTH(16), .DEPTH(16), .NREAD(4), .ZERO_R0(1)) dut1 (
    .clk(clk), .reset(reset),
    .rd_sel(d1_rd_sel), .rd_data(d1_rd_data), .rd_busy(d1_rd_busy),
    .wa_en(d1_wa_en), .wa_sel(d1_wa_sel), .wa_data(d1_wa_data),
    .wb_en(d1_wb_en), .wb_sel(d1_wb_sel), .wb_data(d1_wb_data),
    .rsv_en(d1_rsv_en), .rsv_sel(d1_rsv_sel), .rsv_ok(d1_rsv_ok),
    .busy_vec(d1_busy_vec), .err(d1_err)
  );

  typedef struct {
    int          dut;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input int dut, input int kind, input int idx,
                            input logic [31:0] v, input string nm);
    exp_t e;
    e.dut = dut; e.kind = kind; e.idx = idx; e.exp = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input exp_t e);
    logic [31:0] r;
    logic [1:0]  ix;
    r  = '0;
    ix = e.idx[1:0];
    if (e.dut == 0) begin
      case (e.kind)
        K_DATA:  r = {16'b0, d0_rd_data[ix[0]]};
        K_BUSY:  r = {31'b0, d0_rd_busy[ix[0]]};
        K_BVEC:  r = {24'b0, d0_busy_vec};
        K_ERR:   r = {31'b0, d0_err};
        default: r = {31'b0, d0_rsv_ok};
      endcase
    end else begin
      case (e.kind)
        K_DATA:  r = {16'b0, d1_rd_data[ix]};
        K_BUSY:  r = {31'b0, d1_rd_busy[ix]};
        K_BVEC:  r = {16'b0, d1_busy_vec};
        K_ERR:   r = {31'b0, d1_err};
        default: r = {31'b0, d1_rsv_ok};
      endcase
    end
    return r;
  endfunction

  // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = observe(e);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d0_wa_en = 1'b0; d0_wb_en = 1'b0; d0_rsv_en = 1'b0;
    d1_wa_en = 1'b0; d1_wb_en = 1'b0; d1_rsv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    d0_rd_sel = '0; d0_wa_sel = '0; d0_wb_sel = '0; d0_rsv_sel = '0;
    d0_wa_data = '0; d0_wb_data = '0;
    d1_rd_sel = '0; d1_wa_sel = '0; d1_wb_sel = '0; d1_rsv_sel = '0;
    d1_wa_data = '0; d1_wb_data = '0;
    idle();
    step(); step();
    reset = 1'b0;
    expect_val(0, K_DATA, 0, 32'h0, "rst_rd_data0");
    expect_val(0, K_DATA, 1, 32'h0, "rst_rd_data1");
    expect_val(0, K_BUSY, 0, 32'h0, "rst_rd_busy0");
    expect_val(0, K_BVEC, 0, 32'h0, "rst_busy_vec");
    expect_val(0, K_ERR,  0, 32'h0, "rst_err");
    expect_val(0, K_RSV,  0, 32'h0, "rst_rsv_ok");
    expect_val(1, K_BVEC, 0, 32'h0, "rst1_busy_vec");

    // Plain port A write of R3
    step();
    d0_wa_en = 1'b1; d0_wa_sel = 3'd3; d0_wa_data = 16'h1234; d0_rd_sel[0] = 3'd3;
    expect_val(0, K_DATA, 0, BYP ? 32'h1234 : 32'h0, "wa_r3_same_cycle");
    expect_val(0, K_BUSY, 0, 32'h0, "wa_r3_busy");
    step(); idle();
    expect_val(0, K_DATA, 0, 32'h1234, "wa_r3_next");

    // Reserve R5, blocked port A write, then port B retire
    d0_rsv_en = 1'b1; d0_rsv_sel = 3'd5;
    expect_val(0, K_RSV,  0, 32'h1, "rsv5_ok");
    expect_val(0, K_BVEC, 0, 32'h0, "rsv5_pre_busy");
    step(); idle();
    d0_wa_en = 1'b1; d0_wa_sel = 3'd5; d0_wa_data = 16'hBEEF; d0_rd_sel[1] = 3'd5;
    expect_val(0, K_BVEC, 0, 32'h20, "rsv5_busy_vec");
    expect_val(0, K_BUSY, 1, 32'h1,  "rsv5_rd_busy");
    expect_val(0, K_DATA, 1, 32'h0,  "wa_busy_no_bypass");
    expect_val(0, K_ERR,  0, 32'h0,  "wa_busy_err_pre");
    step(); idle();
    expect_val(0, K_ERR,  0, 32'h1,  "wa_busy_err");
    expect_val(0, K_DATA, 1, 32'h0,  "wa_busy_dropped");
    step();
    d0_wb_en = 1'b1; d0_wb_sel = 3'd5; d0_wb_data = 16'hCAFE;
    expect_val(0, K_DATA, 1, BYP ? 32'hCAFE : 32'h0, "wb_r5_same_cycle");
    expect_val(0, K_BUSY, 1, BYP ? 32'h0 : 32'h1,    "wb_r5_busy_same");
    step(); idle();
    expect_val(0, K_DATA, 1, 32'hCAFE, "wb_r5_data");
    expect_val(0, K_BVEC, 0, 32'h0,    "wb_r5_released");
    expect_val(0, K_ERR,  0, 32'h1,    "err_sticky");

    // Reset clears registers and err
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_val(0, K_DATA, 0, 32'h0, "rst2_r3");
    expect_val(0, K_ERR,  0, 32'h0, "rst2_err");

    // Re-reserve with same-cycle release of R2
    step();
    d0_rsv_en = 1'b1; d0_rsv_sel = 3'd2;
    expect_val(0, K_RSV, 0, 32'h1, "rsv2_ok");
    step();
    expect_val(0, K_RSV, 0, 32'h0, "rsv2_busy_retry");
    step();
    d0_wb_en = 1'b1; d0_wb_sel = 3'd2; d0_wb_data = 16'h0042; d0_rd_sel[0] = 3'd2;
    expect_val(0, K_RSV,  0, 32'h1, "rsv2_with_release");
    expect_val(0, K_DATA, 0, BYP ? 32'h0042 : 32'h0, "rsv2_wb_same_cycle");
    expect_val(0, K_BUSY, 0, 32'h1, "rsv2_busy_same");
    step(); idle();
    expect_val(0, K_DATA, 0, 32'h0042, "rsv2_wb_data");
    expect_val(0, K_BVEC, 0, 32'h04,   "rsv2_stays_busy");
    expect_val(0, K_ERR,  0, 32'h0,    "rsv2_no_err");

    // Both ports to non-busy R1: B wins, B raises err
    d0_wa_en = 1'b1; d0_wa_sel = 3'd1; d0_wa_data = 16'hAAAA;
    d0_wb_en = 1'b1; d0_wb_sel = 3'd1; d0_wb_data = 16'h5555;
    d0_rd_sel[1] = 3'd1;
    expect_val(0, K_DATA, 1, BYP ? 32'h5555 : 32'h0, "ab_r1_same_cycle");
    step(); idle();
    expect_val(0, K_DATA, 1, 32'h5555, "ab_r1_b_wins");
    expect_val(0, K_ERR,  0, 32'h1,    "ab_r1_err");
    expect_val(0, K_BVEC, 0, 32'h04,   "ab_r1_busy_vec");

    // Reset beats same-cycle write and reserve
    reset = 1'b1;
    d0_wa_en = 1'b1; d0_wa_sel = 3'd4; d0_wa_data = 16'h9999;
    d0_rsv_en = 1'b1; d0_rsv_sel = 3'd6;
    expect_val(0, K_RSV, 0, 32'h1, "rst_rsv_comb");
    step(); idle();
    reset = 1'b0;
    d0_rd_sel[0] = 3'd4; d0_rd_sel[1] = 3'd2;
    expect_val(0, K_DATA, 0, 32'h0, "rst3_r4");
    expect_val(0, K_DATA, 1, 32'h0, "rst3_r2");
    expect_val(0, K_BVEC, 0, 32'h0, "rst3_busy_vec");
    expect_val(0, K_ERR,  0, 32'h0, "rst3_err");
    step();
    d0_wb_en = 1'b1; d0_wb_sel = 3'd7; d0_wb_data = 16'h7777; d0_rd_sel[0] = 3'd7;
    expect_val(0, K_DATA, 0, BYP ? 32'h7777 : 32'h0, "wb_r7_same_cycle");
    expect_val(0, K_BUSY, 0, 32'h0, "wb_r7_busy");
    step(); idle();
    expect_val(0, K_DATA, 0, 32'h7777, "wb_r7_data");
    expect_val(0, K_ERR,  0, 32'h1,    "wb_r7_err");

    // Instance 1: four ports, hardwired R0
    d1_wa_en = 1'b1; d1_wa_sel = 4'd1;  d1_wa_data = 16'h0101; step();
    d1_wa_sel = 4'd6;  d1_wa_data = 16'h0606; step();
    d1_wa_sel = 4'd11; d1_wa_data = 16'h0B0B; step();
    d1_wa_sel = 4'd15; d1_wa_data = 16'hF0F0; step();
    idle();
    d1_rd_sel[0] = 4'd1; d1_rd_sel[1] = 4'd6; d1_rd_sel[2] = 4'd11; d1_rd_sel[3] = 4'd15;
    expect_val(1, K_DATA, 0, 32'h0101, "d1_port0");
    expect_val(1, K_DATA, 1, 32'h0606, "d1_port1");
    expect_val(1, K_DATA, 2, 32'h0B0B, "d1_port2");
    expect_val(1, K_DATA, 3, 32'hF0F0, "d1_port3");
    expect_val(1, K_ERR,  0, 32'h0,    "d1_err_clean");
    step();
    d1_wa_en = 1'b1; d1_wa_sel = 4'd0; d1_wa_data = 16'hFFFF; d1_rd_sel[0] = 4'd0;
    expect_val(1, K_DATA, 0, 32'h0, "d1_r0_wa_same_cycle");
    step(); idle();
    expect_val(1, K_DATA, 0, 32'h0, "d1_r0_wa_ignored");
    expect_val(1, K_ERR,  0, 32'h0, "d1_r0_wa_no_err");
    d1_rsv_en = 1'b1; d1_rsv_sel = 4'd0;
    d1_wb_en = 1'b1; d1_wb_sel = 4'd0; d1_wb_data = 16'h1234;
    expect_val(1, K_RSV, 0, 32'h1, "d1_rsv_r0_ok");
    step(); idle();
    expect_val(1, K_BVEC, 0, 32'h0, "d1_r0_never_busy");
    expect_val(1, K_BUSY, 0, 32'h0, "d1_r0_rd_busy");
    expect_val(1, K_ERR,  0, 32'h0, "d1_r0_wb_no_err");
    expect_val(1, K_DATA, 0, 32'h0, "d1_r0_wb_ignored");
    d1_rsv_en = 1'b1; d1_rsv_sel = 4'd15;
    expect_val(1, K_RSV, 0, 32'h1, "d1_rsv15_ok");
    step(); idle();
    expect_val(1, K_BVEC, 0, 32'h8000, "d1_rsv15_busy_vec");
    expect_val(1, K_BUSY, 3, 32'h1,    "d1_rsv15_rd_busy");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
